// File: rtl/phy_rx_lanes_pkg.sv
// Shared types and helpers for the serial PHY receive path.
package phy_rx_lanes_pkg;

    // Alignment FSM states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    // Default alignment/idle symbol; wider words zero-extend it.
    localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phy_rx_lanes_align.sv
// Word alignment: input register, shift window, bit counter and the
// HUNT/COUNT/LOCKED lock FSM. Emits one word strobe per received word while locked.
module phy_rx_lanes_align
    import phy_rx_lanes_pkg::*;
#(
    parameter int           W          = 8,
    parameter logic [W-1:0] COMMA      = W'(DEFAULT_COMMA),
    parameter int           SYNC_COUNT = 4,
    parameter int           LOSS_RUN   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serial_in,
    output logic [W-1:0] word,
    output logic         word_stb,
    output logic         word_is_comma,
    output logic         lock_lost,
    output logic         active,
    output logic         idle_out
);

    localparam int BW = cnt_width(W);
    localparam int RW = cnt_width(SYNC_COUNT + 1);
    localparam int LW = cnt_width(LOSS_RUN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    rx_state_t     state_reg, state_next;
    logic          in_reg;
    logic [W-1:0]  sr_reg;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [RW-1:0] run_reg, run_next;
    logic [LW-1:0] loss_reg, loss_next;
    logic          idle_reg, idle_next;
    logic          sr_is_comma;
    logic          at_strobe;
    logic          run_done;
    logic          loss_done;

    assign sr_is_comma = (sr_reg == COMMA);
    assign at_strobe   = (bit_cnt_reg == LAST_BIT);
    // The comma being counted now completes the required run.
    assign run_done    = (int'(run_reg) + 1 >= SYNC_COUNT);
    // The data word being counted now completes the loss run (0 disables).
    assign loss_done   = (LOSS_RUN != 0) && (int'(loss_reg) + 1 >= LOSS_RUN);

    // Bit capture: one input register, then an MSB-first shift into the word window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_reg <= 1'b0;
            sr_reg <= '0;
        end else begin
            in_reg <= serial_in;
            sr_reg <= {sr_reg[W-2:0], in_reg};
        end
    end

    // Next-state logic: bit-slip search in HUNT, word-rate checks once aligned.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = at_strobe ? '0 : bit_cnt_reg + BW'(1);
        run_next     = run_reg;
        loss_next    = loss_reg;
        word_stb     = 1'b0;
        lock_lost    = 1'b0;
        case (state_reg)
            HUNT: begin
                if (sr_is_comma) begin
                    bit_cnt_next = '0;
                    run_next     = RW'(1);
                    loss_next    = '0;
                    state_next   = (SYNC_COUNT <= 1) ? LOCKED : COUNT;
                end
            end
            COUNT: begin
                if (at_strobe) begin
                    if (sr_is_comma) begin
                        run_next = (run_reg == '1) ? run_reg : run_reg + RW'(1);
                        if (run_done) begin
                            state_next = LOCKED;
                            loss_next  = '0;
                        end
                    end else begin
                        run_next   = '0;
                        state_next = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (at_strobe) begin
                    if (sr_is_comma) begin
                        loss_next = '0;
                        word_stb  = 1'b1;
                    end else if (loss_done) begin
                        // The word that drops lock is not delivered.
                        lock_lost  = 1'b1;
                        loss_next  = '0;
                        run_next   = '0;
                        state_next = HUNT;
                    end else begin
                        loss_next = (loss_reg == '1) ? loss_reg : loss_reg + LW'(1);
                        word_stb  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = HUNT;
                run_next   = '0;
                loss_next  = '0;
            end
        endcase
    end

    // Idle tracks the last locked word and is forced high whenever lock is absent.
    always_comb begin
        idle_next = idle_reg;
        if (state_next != LOCKED) begin
            idle_next = 1'b1;
        end else if (state_reg == LOCKED && at_strobe) begin
            idle_next = sr_is_comma;
        end
    end

    // State, counters and idle flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= HUNT;
            bit_cnt_reg <= '0;
            run_reg     <= '0;
            loss_reg    <= '0;
            idle_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            run_reg     <= run_next;
            loss_reg    <= loss_next;
            idle_reg    <= idle_next;
        end
    end

    assign word          = sr_reg;
    assign word_is_comma = sr_is_comma;
    assign active        = (state_reg == LOCKED);
    assign idle_out      = idle_reg;

endmodule

// File: rtl/phy_rx_lanes.sv
// Serial PHY receiver: comma alignment followed by round-robin distribution of
// received words over NLANES lanes, one frame of NLANES words at a time.
module phy_rx_lanes
    import phy_rx_lanes_pkg::*;
#(
    parameter int           W          = 8,
    parameter int           NLANES     = 4,
    parameter logic [W-1:0] COMMA      = W'(DEFAULT_COMMA),
    parameter int           SYNC_COUNT = 4,
    parameter int           LOSS_RUN   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    output logic [NLANES*W-1:0] data_out,
    output logic [NLANES-1:0]   valid_out,
    output logic                active,
    output logic                idle_out
);

    localparam int SW = cnt_width(NLANES);
    localparam int DW = cnt_width(NLANES * W + 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NLANES - 1);

    logic [W-1:0]          word;
    logic                  word_stb;
    logic                  word_is_comma;
    logic                  lock_lost;
    logic [SW-1:0]         slot_reg;
    logic [NLANES*W-1:0]   frame_data_reg, frame_data_next;
    logic [NLANES-1:0]     frame_valid_reg, frame_valid_next;
    logic [NLANES*W-1:0]   data_out_reg;
    logic [NLANES-1:0]     valid_out_reg;
    logic [DW-1:0]         drain_reg;
    logic [DW-1:0]         drain_init;
    logic                  frame_done;

    phy_rx_lanes_align #(
        .W          (W),
        .COMMA      (COMMA),
        .SYNC_COUNT (SYNC_COUNT),
        .LOSS_RUN   (LOSS_RUN)
    ) u_align (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .word          (word),
        .word_stb      (word_stb),
        .word_is_comma (word_is_comma),
        .lock_lost     (lock_lost),
        .active        (active),
        .idle_out      (idle_out)
    );

    assign frame_done = word_stb && (slot_reg == LAST_SLOT);
    // Cycles from a lock loss at the current slot until that frame would have completed.
    assign drain_init = DW'((NLANES - 1 - int'(slot_reg)) * W);

    // Frame image including the word arriving now, so a completed frame can be
    // loaded straight into the output registers without an extra cycle.
    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_slot
            logic hit;
            assign hit = word_stb && (slot_reg == SW'(gi));
            assign frame_data_next[gi*W +: W] =
                hit ? (word_is_comma ? '0 : word) : frame_data_reg[gi*W +: W];
            assign frame_valid_next[gi] = hit ? ~word_is_comma : frame_valid_reg[gi];
        end
    endgenerate

    // Slot pointer and partial-frame buffer; restarts at slot 0 on every lock entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_reg        <= '0;
            frame_data_reg  <= '0;
            frame_valid_reg <= '0;
        end else if (!active || lock_lost) begin
            slot_reg        <= '0;
            frame_valid_reg <= '0;
        end else if (word_stb) begin
            slot_reg        <= (slot_reg == LAST_SLOT) ? '0 : slot_reg + SW'(1);
            frame_data_reg  <= frame_data_next;
            frame_valid_reg <= frame_valid_next;
        end
    end

    // Output frame registers; after a lock loss valid_out drops at the frame
    // boundary the lost frame would have reached, while data_out keeps its value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_reg  <= '0;
            valid_out_reg <= '0;
            drain_reg     <= '0;
        end else if (frame_done) begin
            data_out_reg  <= frame_data_next;
            valid_out_reg <= frame_valid_next;
            drain_reg     <= '0;
        end else if (lock_lost) begin
            if (slot_reg == LAST_SLOT) begin
                valid_out_reg <= '0;
            end else begin
                drain_reg <= drain_init;
            end
        end else if (drain_reg != '0) begin
            drain_reg <= drain_reg - DW'(1);
            if (drain_reg == DW'(1)) begin
                valid_out_reg <= '0;
            end
        end
    end

    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Directed bench for phy_rx_lanes: an 8-bit/4-lane instance and a 10-bit/2-lane instance.
module tb_phy_rx_lanes;

    localparam int P_DATA  = 0;
    localparam int P_VALID = 1;
    localparam int P_ACT   = 2;
    localparam int P_IDLE  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ser_a, ser_b;
    logic [31:0] data_a;
    logic [3:0]  valid_a;
    logic        active_a, idle_a;
    logic [19:0] data_b;
    logic [1:0]  valid_b;
    logic        active_b, idle_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    phy_rx_lanes #(.W(8), .NLANES(4), .COMMA(8'hBC), .SYNC_COUNT(4), .LOSS_RUN(16)) u_a (
        .clk(clk), .rst(rst), .serial_in(ser_a), .data_out(data_a),
        .valid_out(valid_a), .active(active_a), .idle_out(idle_a)
    );

    phy_rx_lanes #(.W(10), .NLANES(2), .COMMA(10'h17C), .SYNC_COUNT(4), .LOSS_RUN(16)) u_b (
        .clk(clk), .rst(rst), .serial_in(ser_b), .data_out(data_b),
        .valid_out(valid_b), .active(active_b), .idle_out(idle_b)
    );

    typedef struct {
        logic [3:0][15:0] w;
        logic [31:0]      data;
        logic [3:0]       valid;
        logic             idle;
    } vec_t;

    typedef struct {
        int          due;
        string       name;
        bit          b;
        int          sel;
        logic [31:0] exp;
    } pend_t;

    vec_t  vecs_a[5];
    vec_t  vecs_b[4];
    pend_t pend[$];

    function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [31:0] d, input logic [3:0] v, input logic idle);
        vec_t r;
        r.w[0] = w0; r.w[1] = w1; r.w[2] = w2; r.w[3] = w3;
        r.data = d; r.valid = v; r.idle = idle;
        return r;
    endfunction

    function automatic logic [31:0] probe(input bit b, input int sel);
        case (sel)
            P_DATA:  return b ? 32'(data_b)   : data_a;
            P_VALID: return b ? 32'(valid_b)  : 32'(valid_a);
            P_ACT:   return b ? 32'(active_b) : 32'(active_a);
            default: return b ? 32'(idle_b)   : 32'(idle_a);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // Schedule a comparison dly negedges from now (dly >= 1).
    task automatic check_at(input string name, input int dly, input bit b,
                            input int sel, input logic [31:0] exp);
        pend_t p;
        p.due = cyc + dly; p.name = name; p.b = b; p.sel = sel; p.exp = exp;
        pend.push_back(p);
    endtask

    // Drive n bits of val MSB first, one per clock, changing on the falling edge.
    task automatic send(input bit b, input logic [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (b) ser_b = val[i];
            else   ser_a = val[i];
        end
    endtask

    task automatic lock_seq(input bit b, input string tag);
        logic [15:0] c;
        int          n;
        c = b ? 16'h17C : 16'h0BC;
        n = b ? 10 : 8;
        for (int k = 1; k <= 4; k++) begin
            send(b, c, n);
            if (k == 3) check_at({tag, ".active_after_3_commas"}, 3, b, P_ACT, 0);
        end
        check_at({tag, ".active_early"}, 2, b, P_ACT, 0);
        check_at({tag, ".active_rise"},  3, b, P_ACT, 1);
        check_at({tag, ".idle_locked"},  3, b, P_IDLE, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    check(pend[i].name, probe(pend[i].b, pend[i].sel), pend[i].exp);
                    pend.delete(i);
                end
            end
        end
    end

    initial begin
        vecs_a[0] = mk(16'h11, 16'h22, 16'h33, 16'h44, 32'h44332211, 4'hF, 1'b0);
        vecs_a[1] = mk(16'h11, 16'hBC, 16'h33, 16'hBC, 32'h00330011, 4'h5, 1'b1);
        vecs_a[2] = mk(16'hA5, 16'h5A, 16'hBC, 16'hFF, 32'hFF005AA5, 4'hB, 1'b0);
        vecs_a[3] = mk(16'hBC, 16'hBC, 16'hBC, 16'hBC, 32'h00000000, 4'h0, 1'b1);
        vecs_a[4] = mk(16'h01, 16'h02, 16'h03, 16'hBC, 32'h00030201, 4'h7, 1'b1);
        vecs_b[0] = mk(16'h001, 16'h002, 16'h0, 16'h0, 32'h00801, 4'h3, 1'b0);
        vecs_b[1] = mk(16'h3FF, 16'h17C, 16'h0, 16'h0, 32'h003FF, 4'h1, 1'b1);
        vecs_b[2] = mk(16'h17C, 16'h155, 16'h0, 16'h0, 32'h55400, 4'h2, 1'b0);
        vecs_b[3] = mk(16'h17C, 16'h17C, 16'h0, 16'h0, 32'h00000, 4'h0, 1'b1);

        // Reset state
        rst = 1'b0; ser_a = 1'b0; ser_b = 1'b0;
        repeat (3) @(negedge clk);
        check("A.reset.data",   data_a, 0);
        check("A.reset.valid",  32'(valid_a), 0);
        check("A.reset.active", 32'(active_a), 0);
        check("A.reset.idle",   32'(idle_a), 1);
        check("B.reset.data",   32'(data_b), 0);
        check("B.reset.idle",   32'(idle_b), 1);
        @(negedge clk);
        rst = 1'b1;

        // A: noise, commas 3 bits late, lock
        send(0, 16'b010, 3);
        lock_seq(0, "A.lock");

        // A: table-driven frames
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) send(0, vecs_a[v].w[k], 8);
            if (v == 0) check_at("A.vec0.valid_not_early", 2, 0, P_VALID, 0);
            check_at($sformatf("A.vec%0d.data", v),  3, 0, P_DATA,  vecs_a[v].data);
            check_at($sformatf("A.vec%0d.valid", v), 3, 0, P_VALID, 32'(vecs_a[v].valid));
            check_at($sformatf("A.vec%0d.idle", v),  3, 0, P_IDLE,  32'(vecs_a[v].idle));
        end

        // A: comma then 16 data words; lock drops at slot 0, valid drains 3 words later
        send(0, 16'hBC, 8);
        for (int k = 1; k <= 16; k++) begin
            send(0, 16'h55, 8);
            if (k == 3) begin
                check_at("A.loss.frame0.data",  3, 0, P_DATA,  32'h55555500);
                check_at("A.loss.frame0.valid", 3, 0, P_VALID, 4'hE);
            end
            if (k == 15) begin
                check_at("A.loss.frame3.data",  3, 0, P_DATA,  32'h55555555);
                check_at("A.loss.frame3.valid", 3, 0, P_VALID, 4'hF);
            end
        end
        check_at("A.loss.active_before", 2,  0, P_ACT,   1);
        check_at("A.loss.active_fall",   3,  0, P_ACT,   0);
        check_at("A.loss.idle",          3,  0, P_IDLE,  1);
        check_at("A.loss.valid_held",    26, 0, P_VALID, 4'hF);
        check_at("A.loss.valid_cleared", 27, 0, P_VALID, 0);
        check_at("A.loss.data_held",     27, 0, P_DATA,  32'h55555555);
        lock_seq(0, "A.relock");

        // A: reset mid-frame after two data words
        send(0, 16'h12, 8);
        send(0, 16'h34, 8);
        send(0, 16'h5, 4);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("A.midreset.data",   data_a, 0);
        check("A.midreset.valid",  32'(valid_a), 0);
        check("A.midreset.active", 32'(active_a), 0);
        check("A.midreset.idle",   32'(idle_a), 1);
        @(negedge clk);
        rst = 1'b1; ser_a = 1'b0;
        lock_seq(0, "A.postreset");
        send(0, 16'hDE, 8); send(0, 16'hAD, 8); send(0, 16'hBE, 8); send(0, 16'hEF, 8);
        check_at("A.postreset.valid_not_early", 2, 0, P_VALID, 0);
        check_at("A.postreset.data",  3, 0, P_DATA,  32'hEFBEADDE);
        check_at("A.postreset.valid", 3, 0, P_VALID, 4'hF);

        // B: W=10, NLANES=2, COMMA=10'h17C
        send(1, 16'b110, 3);
        lock_seq(1, "B.lock");
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 2; k++) send(1, vecs_b[v].w[k], 10);
            if (v == 0) check_at("B.vec0.valid_not_early", 2, 1, P_VALID, 0);
            check_at($sformatf("B.vec%0d.data", v),  3, 1, P_DATA,  vecs_b[v].data);
            check_at($sformatf("B.vec%0d.valid", v), 3, 1, P_VALID, 32'(vecs_b[v].valid));
            check_at($sformatf("B.vec%0d.idle", v),  3, 1, P_IDLE,  32'(vecs_b[v].idle));
        end
        for (int k = 1; k <= 16; k++) begin
            send(1, 16'h155, 10);
            if (k == 14) begin
                check_at("B.loss.last_frame.data",  3, 1, P_DATA,  32'h55555);
                check_at("B.loss.last_frame.valid", 3, 1, P_VALID, 4'h3);
            end
        end
        check_at("B.loss.active_before", 2, 1, P_ACT,   1);
        check_at("B.loss.active_fall",   3, 1, P_ACT,   0);
        check_at("B.loss.valid_cleared", 3, 1, P_VALID, 0);
        check_at("B.loss.data_held",     3, 1, P_DATA,  32'h55555);
        lock_seq(1, "B.relock");

        for (int i = 0; i < 100 && pend.size() != 0; i++) @(negedge clk);
        if (pend.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL pending_checks: got %0d outstanding, expected 0", pend.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
